inst_fetch_unit: RTL and testbench

Front end of the R/I/J pipeline: generates the program counter, issues in-order word reads to instruction memory, buffers returned words, and presents them with their PC as the 32-bit `ir` consumed by the instruction decoder. It is the producer side of the decoder's instruction-register interface. Taken branches and jumps arrive as a redirect from a later stage; stale in-flight fetches are squashed. Cycles with no valid instruction are filled with the NOP encoding, opcode `6'b111111`.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 38 +++
 rtl/inst_fetch_unit.sv | 80 ++++++++
 tb/tb_inst_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared across the R/I/J pipeline front end
package cpu_pkg;
    localparam logic [5:0] OP_NOP = 6'b111111;
    localparam logic [31:0] NOP_INST = {OP_NOP, 26'b0};
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic {RUN, SQUASH} mode_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: response buffer of {pc, word} entries; head comes straight from storage flops
module fetch_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [63:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic [63:0]   head
);
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation, credit-limited imem fetch, redirect squash, and ir presentation
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc, rsp_pc;
    logic [CW-1:0] outstanding, outstanding_next, discard, count;
    logic [CW:0]   credit_used;
    logic [63:0]   head;
    logic          pop, req_fire, push;
    mode_t         mode;

    assign pop              = ir_valid && ir_ready;
    assign credit_used      = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
    assign imem_req_valid   = !rst && credit_used < (CW+1)'(DEPTH);
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    // Kept requests are contiguous up to pc-4, so the oldest one sits outstanding words back.
    assign rsp_pc           = pc - 32'({outstanding, 2'b00});
    assign push             = imem_rsp_valid && mode == RUN;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data({rsp_pc, imem_rsp_data}),
        .pop      (pop),
        .flush    (redirect_valid),
        .count    (count),
        .head     (head)
    );

    assign ir_valid = count != '0;
    assign ir       = ir_valid ? head[31:0] : NOP_INST;
    assign ir_pc    = ir_valid ? head[63:32] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            outstanding <= '0;
            discard     <= '0;
            mode        <= RUN;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc      <= {redirect_pc[31:2], 2'b00};
                discard <= outstanding_next;
                mode    <= (outstanding_next != '0) ? SQUASH : RUN;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (imem_rsp_valid && mode == SQUASH) begin
                    discard <= discard - CW'(1);
                    if (discard == CW'(1)) mode <= RUN;
                end
            end
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, outstanding} + {1'b0, count}) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: table vectors, directed corner sequences and random traffic against a queue model
module tb_inst_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'hFC00_0000;

    logic        clk = 0, rst = 1;
    logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
    logic [31:0] imem_req_addr, imem_rsp_data = 0;
    logic        redirect_valid = 0, ir_valid, ir_ready = 0;
    logic [31:0] redirect_pc = 0, ir, ir_pc;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; int due;} mreq_t;
    typedef struct packed {logic [31:0] pc; logic stale;} inf_t;
    typedef struct packed {logic [31:0] pc; logic [31:0] data;} ent_t;
    typedef struct {
        logic irr; logic e_irv; logic [31:0] e_pc; logic [31:0] e_ir; logic e_req; logic [31:0] e_addr;
    } vec_t;

    mreq_t       mq[$];
    inf_t        iq[$];
    ent_t        fq[$];
    logic [31:0] m_pc = RESET_PC;
    int          cyc = 0, lat = 1, n_vec = 0, n_err = 0;
    logic        s_irv, s_req;
    logic [31:0] s_ir, s_pc, s_addr;
    vec_t        tbl[13];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {6'b001000, a[27:2]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance memory and model at the edge.
    task automatic cycle(input logic r, input logic rdy, input logic irr, input logic rd, input logic [31:0] rpc);
        logic        e_irv, e_req, pop, rsp_take, mfire;
        logic [31:0] e_ir, e_pc, m_addr;
        inf_t        f;
        rst = r; imem_req_ready = rdy; ir_ready = irr; redirect_valid = rd; redirect_pc = rpc;
        rsp_take = !r && mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_valid = rsp_take;
        imem_rsp_data = rsp_take ? mem_word(mq[0].addr) : $urandom;
        e_irv = fq.size() > 0;
        e_ir  = e_irv ? fq[0].data : NOP;
        e_pc  = e_irv ? fq[0].pc : 32'h0;
        pop   = e_irv && irr;
        e_req = !r && (iq.size() + fq.size() - int'(pop)) < DEPTH;
        #3;
        s_irv = ir_valid; s_ir = ir; s_pc = ir_pc; s_req = imem_req_valid; s_addr = imem_req_addr;
        check("ir_valid", 32'(s_irv), 32'(e_irv));
        check("ir", s_ir, e_ir);
        check("ir_pc", s_pc, e_pc);
        check("req_valid", 32'(s_req), 32'(e_req));
        check("req_addr", s_addr, m_pc);
        mfire = s_req && rdy && !r;
        m_addr = s_addr;
        @(posedge clk);
        if (r) begin
            mq.delete(); iq.delete(); fq.delete(); m_pc = RESET_PC;
        end else begin
            if (rsp_take) void'(mq.pop_front());
            if (mfire) mq.push_back('{addr: m_addr, due: cyc + lat});
            if (pop) void'(fq.pop_front());
            if (rsp_take && iq.size() > 0) begin
                f = iq.pop_front();
                if (!f.stale) fq.push_back('{pc: f.pc, data: mem_word(f.pc)});
            end
            if (e_req && rdy) begin
                iq.push_back('{pc: m_pc, stale: 1'b0});
                m_pc += 32'd4;
            end
            if (rd) begin
                fq.delete();
                foreach (iq[i]) iq[i].stale = 1'b1;
                m_pc = {rpc[31:2], 2'b00};
            end
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
    endtask

    task automatic run(input int n, input logic irr);
        for (int i = 0; i < n; i++) cycle(0, 1, irr, 0, 0);
    endtask

    initial begin
        logic        found;
        logic [31:0] seen[$];
        tbl[0]  = '{1, 0, 32'h00, NOP,          1, 32'h00};
        tbl[1]  = '{1, 0, 32'h00, NOP,          1, 32'h04};
        tbl[2]  = '{1, 1, 32'h00, 32'h2000_0000, 1, 32'h08};
        tbl[3]  = '{1, 1, 32'h04, 32'h2000_0001, 1, 32'h0C};
        tbl[4]  = '{1, 1, 32'h08, 32'h2000_0002, 1, 32'h10};
        tbl[5]  = '{0, 1, 32'h0C, 32'h2000_0003, 0, 32'h14};
        tbl[6]  = '{0, 1, 32'h0C, 32'h2000_0003, 0, 32'h14};
        tbl[7]  = '{0, 1, 32'h0C, 32'h2000_0003, 0, 32'h14};
        tbl[8]  = '{0, 1, 32'h0C, 32'h2000_0003, 0, 32'h14};
        tbl[9]  = '{0, 1, 32'h0C, 32'h2000_0003, 0, 32'h14};
        tbl[10] = '{1, 1, 32'h0C, 32'h2000_0003, 1, 32'h14};
        tbl[11] = '{1, 1, 32'h10, 32'h2000_0004, 1, 32'h18};
        tbl[12] = '{1, 1, 32'h14, 32'h2000_0005, 1, 32'h1C};
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("rst_req_valid", 32'(s_req), 0);
        check("rst_addr", s_addr, RESET_PC);
        check("rst_ir", s_ir, NOP);
        check("rst_ir_pc", s_pc, 0);

        // straight-line fetch then a 5-cycle stall, 1-cycle memory
        lat = 1;
        foreach (tbl[i]) begin
            cycle(0, 1, tbl[i].irr, 0, 0);
            check("tbl_ir_valid", 32'(s_irv), 32'(tbl[i].e_irv));
            check("tbl_ir_pc", s_pc, tbl[i].e_pc);
            check("tbl_ir", s_ir, tbl[i].e_ir);
            check("tbl_req_valid", 32'(s_req), 32'(tbl[i].e_req));
            check("tbl_req_addr", s_addr, tbl[i].e_addr);
        end

        // redirect with two fetches in flight, 3-cycle memory
        do_reset();
        lat = 3;
        run(2, 1);
        cycle(0, 1, 1, 1, 32'h40);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(0, 1, 1, 0, 0);
            if (s_irv) begin
                found = 1;
                check("rdr_first_pc", s_pc, 32'h40);
                check("rdr_first_ir", s_ir, 32'h2000_0010);
            end else check("rdr_gap_nop", s_ir, NOP);
        end
        if (!found) check("rdr_timeout", 0, 1);

        // redirect in the same cycle as a response and an IR handshake
        do_reset();
        lat = 1;
        run(4, 1);
        cycle(0, 1, 1, 1, 32'h100);
        check("coin_handshake", 32'(s_irv), 1);
        cycle(0, 1, 1, 0, 0);
        check("coin_after_nop", 32'(s_irv), 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 1, 1, 0, 0);
            if (s_irv) begin
                found = 1;
                check("coin_first_pc", s_pc, 32'h100);
            end
        end
        if (!found) check("coin_timeout", 0, 1);

        // PC wrap
        do_reset();
        run(2, 1);
        cycle(0, 1, 1, 1, 32'hFFFF_FFFF);
        for (int i = 0; i < 10 && seen.size() < 3; i++) begin
            cycle(0, 1, 1, 0, 0);
            if (s_req) seen.push_back(s_addr);
        end
        if (seen.size() == 3) begin
            check("wrap_a0", seen[0], 32'hFFFF_FFFC);
            check("wrap_a1", seen[1], 32'h0);
            check("wrap_a2", seen[2], 32'h4);
        end else check("wrap_timeout", seen.size(), 3);
        run(4, 1);

        // reset with a full FIFO
        run(2, 0);
        check("mid_full", 32'(s_req), 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        check("mid_ir_valid", 32'(s_irv), 0);
        check("mid_ir", s_ir, NOP);
        check("mid_ir_pc", s_pc, 0);
        check("mid_req", 32'(s_req), 1);
        check("mid_addr", s_addr, RESET_PC);
        run(4, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
